// File: rtl/expr_pkg.sv
// Shared definitions for the expression evaluator: opcodes, notation select and FSM states.
// No logic here; types and constants only.
package expr_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_MAX = 2'd3;

  localparam logic NOT_PREFIX  = 1'b0;
  localparam logic NOT_POSTFIX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_OUT
  } state_t;

endpackage

// File: rtl/expr_alu.sv
// Combinational binary operator for the evaluator stack: add/sub/mul/signed max, wrapping at RES_W.
// Zero latency; no flow control.
module expr_alu
  import expr_pkg::*;
#(
  parameter int RES_W = 32
) (
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  input  logic [1:0]       opcode,
  output logic [RES_W-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_MAX:  result = ($signed(a) > $signed(b)) ? a : b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/expr_eval.sv
// Stack evaluator for prefix/postfix token streams; result N+1 cycles after the stream ends.
// No backpressure: tokens arriving during EVAL/OUT are dropped, excess tokens flag an error.
module expr_eval
  import expr_pkg::*;
#(
  parameter int DATA_W  = 5,
  parameter int MAX_TOK = 19,
  parameter int RES_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              opt,
  input  logic              in_is_op,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [RES_W-1:0]  out,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_TOK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TOK);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_t state, state_nxt;

  logic              tok_op  [MAX_TOK];
  logic [DATA_W-1:0] tok_dat [MAX_TOK];
  logic [RES_W-1:0]  stk     [MAX_TOK];

  logic [CNT_W-1:0] cnt, step, sp;
  logic             mode, err_acc;

  logic [CNT_W-1:0] tok_idx, idx_top, idx_nxt, wr_idx, sp_nxt;
  logic             cur_op, wr_en, pop_err, last_step, err_fin;
  logic [DATA_W-1:0] cur_dat;
  logic [RES_W-1:0] top_val, nxt_val, alu_a, alu_b, alu_y, wr_val;

  assign last_step = (step == cnt - ONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_LOAD;
      ST_LOAD: if (!in_valid) state_nxt = ST_EVAL;
      ST_EVAL: if (last_step) state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Prefix walks the buffer backwards so both notations reduce with the same stack machine.
  always_comb begin
    tok_idx = (mode == NOT_POSTFIX) ? step : (cnt - ONE - step);
    cur_op  = tok_op[tok_idx];
    cur_dat = tok_dat[tok_idx];
    idx_top = (sp != '0) ? (sp - ONE) : '0;
    idx_nxt = (sp >= TWO) ? (sp - TWO) : '0;
    top_val = stk[idx_top];
    nxt_val = stk[idx_nxt];
    alu_a   = (mode == NOT_POSTFIX) ? nxt_val : top_val;
    alu_b   = (mode == NOT_POSTFIX) ? top_val : nxt_val;
    wr_en   = 1'b0;
    wr_idx  = sp;
    wr_val  = '0;
    sp_nxt  = sp;
    pop_err = 1'b0;
    if (!cur_op) begin
      wr_en  = 1'b1;
      wr_val = {{(RES_W-DATA_W){1'b0}}, cur_dat};
      sp_nxt = sp + ONE;
    end else if (sp < TWO) begin
      pop_err = 1'b1;
    end else begin
      wr_en  = 1'b1;
      wr_idx = sp - TWO;
      wr_val = alu_y;
      sp_nxt = sp - ONE;
    end
    err_fin = err_acc | pop_err | (sp_nxt != ONE);
  end

  expr_alu #(.RES_W(RES_W)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .opcode (cur_dat[1:0]),
    .result (alu_y)
  );

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      tok_op[0]  <= in_is_op;
      tok_dat[0] <= in_data;
    end
    if (state == ST_LOAD && in_valid && cnt < MAX_CNT) begin
      tok_op[cnt]  <= in_is_op;
      tok_dat[cnt] <= in_data;
    end
    if (state == ST_EVAL && wr_en) stk[wr_idx] <= wr_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      step      <= '0;
      sp        <= '0;
      mode      <= NOT_PREFIX;
      err_acc   <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out       <= '0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: if (in_valid) begin
          cnt     <= ONE;
          step    <= '0;
          sp      <= '0;
          mode    <= opt;
          err_acc <= 1'b0;
        end
        ST_LOAD: if (in_valid) begin
          if (cnt < MAX_CNT) cnt <= cnt + ONE;
          else               err_acc <= 1'b1;
        end
        ST_EVAL: begin
          sp      <= sp_nxt;
          step    <= step + ONE;
          err_acc <= err_acc | pop_err;
          if (last_step) begin
            out_valid <= 1'b1;
            err       <= err_fin;
            out       <= err_fin ? '0 : wr_val;
          end
        end
        ST_OUT: begin
          sp  <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: hand-computed results, latency and error cases.
module tb_expr_eval;

  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h21;
  localparam logic [5:0] MUL = 6'h22;
  localparam logic [5:0] MAX = 6'h23;
  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        opt = 1'b0;
  logic        in_is_op = 1'b0;
  logic [4:0]  in_data = '0;
  logic        out_valid;
  logic [31:0] out;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  expr_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .opt       (opt),
    .in_is_op  (in_is_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out       (out),
    .err       (err)
  );

  // Streams tokens, then waits for out_valid; lat counts cycles from the first idle-input cycle.
  task automatic run_expr(input logic [5:0] toks[$], input logic o, input int p_lo, input int p_hi,
                          output int lat, output logic [31:0] r, output logic e);
    @(posedge clk); #1;
    for (int i = 0; i < toks.size(); i++) begin
      in_valid = 1'b1;
      opt      = (i == 0) ? o : ~o;
      in_is_op = toks[i][5];
      in_data  = toks[i][4:0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    r = '0;
    e = 1'b0;
    while (lat < LIMIT) begin
      @(negedge clk);
      if (out_valid) begin
        r = out;
        e = err;
        break;
      end
      in_valid = (lat >= p_lo && lat <= p_hi);
      in_is_op = 1'b0;
      in_data  = 5'd9;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out, err} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset: valid=%b out=%h err=%b required all zero", out_valid, out, err);
    end
    rst = 1'b0;
  endtask

  task automatic check_res(input string name, input int lat, input int lat_exp,
                           input logic [31:0] r, input logic [31:0] r_exp,
                           input logic e, input logic e_exp);
    n_cmp++;
    if (lat !== lat_exp || r !== r_exp || e !== e_exp) begin
      n_bad++;
      $display("FAIL %s: lat=%0d out=%h err=%b required lat=%0d out=%h err=%b",
               name, lat, r, e, lat_exp, r_exp, e_exp);
    end
  endtask

  task automatic test_prefix;
    int lat; logic [31:0] r; logic e;
    run_expr('{ADD, 6'd3, MUL, 6'd4, 6'd5}, 1'b0, -1, -1, lat, r, e);
    check_res("prefix_add_mul", lat, 6, r, 32'd23, e, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out !== 32'd0) begin
      n_bad++;
      $display("FAIL strobe_width: valid=%b out=%h required 0/0", out_valid, out);
    end
    run_expr('{SUB, 6'd2, 6'd7}, 1'b0, -1, -1, lat, r, e);
    check_res("prefix_sub_neg", lat, 4, r, 32'hFFFF_FFFB, e, 1'b0);
    run_expr('{MAX, SUB, 6'd1, 6'd9, 6'd3}, 1'b0, -1, -1, lat, r, e);
    check_res("prefix_max", lat, 6, r, 32'd3, e, 1'b0);
    run_expr('{MUL, 6'd31, 6'd31}, 1'b0, -1, -1, lat, r, e);
    check_res("prefix_mul_max_operand", lat, 4, r, 32'd961, e, 1'b0);
  endtask

  task automatic test_postfix;
    int lat; logic [31:0] r; logic e;
    logic [5:0] t[$];
    run_expr('{6'd3, 6'd4, 6'd5, MUL, ADD}, 1'b1, -1, -1, lat, r, e);
    check_res("postfix_add_mul", lat, 6, r, 32'd23, e, 1'b0);
    run_expr('{6'd2, 6'd7, SUB}, 1'b1, -1, -1, lat, r, e);
    check_res("postfix_sub_order", lat, 4, r, 32'hFFFF_FFFB, e, 1'b0);
    run_expr('{6'd7}, 1'b1, -1, -1, lat, r, e);
    check_res("postfix_single", lat, 2, r, 32'd7, e, 1'b0);
    t.push_back(6'd31);
    for (int i = 0; i < 6; i++) begin
      t.push_back(6'd31);
      t.push_back(MUL);
    end
    run_expr(t, 1'b1, -1, -1, lat, r, e);
    check_res("postfix_mul_wrap", lat, 14, r, 32'd1742810335, e, 1'b0);
  endtask

  task automatic test_errors;
    int lat; logic [31:0] r; logic e;
    run_expr('{ADD, 6'd3}, 1'b0, -1, -1, lat, r, e);
    check_res("prefix_underflow", lat, 3, r, 32'd0, e, 1'b1);
    run_expr('{6'd3, 6'd4}, 1'b1, -1, -1, lat, r, e);
    check_res("postfix_leftover", lat, 3, r, 32'd0, e, 1'b1);
    run_expr('{6'd3, ADD, 6'd4}, 1'b1, -1, -1, lat, r, e);
    check_res("postfix_pop_empty", lat, 4, r, 32'd0, e, 1'b1);
  endtask

  task automatic test_max_tok;
    int lat; logic [31:0] r; logic e;
    logic [5:0] t[$];
    for (int i = 0; i < 9; i++) t.push_back(ADD);
    for (int i = 0; i < 10; i++) t.push_back(6'd1);
    run_expr(t, 1'b0, -1, -1, lat, r, e);
    check_res("tok19_ok", lat, 20, r, 32'd10, e, 1'b0);
    t.push_back(6'd1);
    run_expr(t, 1'b0, -1, -1, lat, r, e);
    check_res("tok20_overflow", lat, 20, r, 32'd0, e, 1'b1);
  endtask

  task automatic test_eval_pulse;
    int lat; logic [31:0] r; logic e;
    run_expr('{ADD, 6'd3, MUL, 6'd4, 6'd5}, 1'b0, 1, 5, lat, r, e);
    check_res("pulse_in_eval", lat, 6, r, 32'd23, e, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] r; logic e;
    run_expr('{6'd6, 6'd5, SUB}, 1'b1, -1, -1, lat, r, e);
    check_res("b2b_first", lat, 4, r, 32'd1, e, 1'b0);
    run_expr('{MUL, 6'd6, 6'd5}, 1'b0, -1, -1, lat, r, e);
    check_res("b2b_second", lat, 4, r, 32'd30, e, 1'b0);
  endtask

  task automatic test_mid_reset;
    int lat; int seen; logic [31:0] r; logic e;
    @(posedge clk); #1;
    in_valid = 1'b1; opt = 1'b0; in_is_op = 1'b1; in_data = 5'd0;
    @(posedge clk); #1;
    in_is_op = 1'b0; in_data = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset_out: valid=%b out=%h required 0/0", out_valid, out);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_discard: strobes=%0d required 0", seen);
    end
    run_expr('{ADD, 6'd3, MUL, 6'd4, 6'd5}, 1'b0, -1, -1, lat, r, e);
    check_res("after_reset", lat, 6, r, 32'd23, e, 1'b0);
  endtask

  initial begin
    test_reset();
    test_prefix();
    test_postfix();
    test_errors();
    test_max_tok();
    test_eval_pulse();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
